// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bundle for the pipelined barrel shifter: input operand side and result side.
// The slave modport is the shifter's view; the master modport is the producer/consumer view.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] amt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, amt, mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, amt, mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// WIDTH-bit rotate/shift unit (rotl, rotr, shl, asr), one log2 step per pipeline register,
// largest step first, with a single global advance shared by every stage.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input logic                       clk,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus
);
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
    end
    if (AMT_W != $clog2(WIDTH)) begin : g_bad_amt_w
        $error("pipelined_barrel_shifter: AMT_W must equal log2(WIDTH)");
    end

    function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       m,
                                                  input int unsigned      d);
        logic [WIDTH-1:0] y;
        unique case (m)
            2'b00:   y = (x << d) | (x >> (WIDTH - d));
            2'b01:   y = (x >> d) | (x << (WIDTH - d));
            2'b10:   y = x << d;
            default: y = WIDTH'($signed(x) >>> d);
        endcase
        return y;
    endfunction

    logic                              w_adv;
    logic [AMT_W-1:0]                  r_valid;
    logic [AMT_W-1:0][WIDTH-1:0]       r_data;
    logic [AMT_W-1:0][AMT_W-1:0]       r_amt;
    logic [AMT_W-1:0][1:0]             r_mode;

    // Every stage moves together; a full last stage blocks the whole pipe.
    assign w_adv         = ~r_valid[AMT_W-1] | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_valid[AMT_W-1];
    assign bus.out_data  = r_data[AMT_W-1];

    for (genvar s = 0; s < AMT_W; s++) begin : g_stage
        localparam int unsigned Dist = 1 << (AMT_W - 1 - s);

        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;
        logic [AMT_W-1:0] w_src_amt;
        logic [1:0]       w_src_mode;
        logic [WIDTH-1:0] w_nxt_data;

        if (s == 0) begin : g_head
            assign w_src_valid = bus.in_valid;
            assign w_src_data  = bus.in_data;
            assign w_src_amt   = bus.amt;
            assign w_src_mode  = bus.mode;
        end else begin : g_body
            assign w_src_valid = r_valid[s-1];
            assign w_src_data  = r_data[s-1];
            assign w_src_amt   = r_amt[s-1];
            assign w_src_mode  = r_mode[s-1];
        end

        assign w_nxt_data = w_src_amt[AMT_W-1-s] ? stage_op(w_src_data, w_src_mode, Dist)
                                                 : w_src_data;

        // Data only loads behind a valid word so out_data stays 0 from reset to first result.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid[s] <= 1'b0;
                r_data[s]  <= '0;
                r_amt[s]   <= '0;
                r_mode[s]  <= '0;
            end else if (w_adv) begin
                r_valid[s] <= w_src_valid;
                r_amt[s]   <= w_src_amt;
                r_mode[s]  <= w_src_mode;
                if (w_src_valid) begin
                    r_data[s] <= w_nxt_data;
                end
            end
        end
    end

    // Each stage consumes only one amt bit and the last stage needs no control fields.
    logic w_unused;
    assign w_unused = ^{r_amt, r_mode[AMT_W-1]};
endmodule
